// File: rtl/axi_4lite_master.sv
// AXI4-Lite initiator: one user command in, one AXI4-Lite transaction out, one response back.
// Optional `AXI_MASTER_ALIGN_CHECK_EN` rejects misaligned commands locally with SLVERR.
module axi_4lite_master #(
  parameter int          AXI_Dwidth    = 32,
  parameter int          AXI_Addrwidth = 4,
  parameter logic [2:0]  AXI_Prot      = 3'b000
) (
  input  logic                       AXI_aclk,
  input  logic                       AXI_aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AXI_Addrwidth-1:0]   cmd_addr,
  input  logic [AXI_Dwidth-1:0]      cmd_wdata,
  input  logic [AXI_Dwidth/8-1:0]    cmd_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [AXI_Dwidth-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic [AXI_Addrwidth-1:0]   AXI_awaddr,
  output logic                       AXI_awvalid,
  input  logic                       AXI_awready,
  output logic [AXI_Dwidth-1:0]      AXI_wdata,
  output logic [AXI_Dwidth/8-1:0]    AXI_wstrb,
  output logic                       AXI_wvalid,
  input  logic                       AXI_wready,
  input  logic [1:0]                 AXI_bresp,
  input  logic                       AXI_bvalid,
  output logic                       AXI_bready,
  output logic [AXI_Addrwidth-1:0]   AXI_areadaddr,
  output logic [2:0]                 AXI_arprotect,
  output logic                       AXI_arvalid,
  input  logic                       AXI_arready,
  input  logic [AXI_Dwidth-1:0]      AXI_rdata,
  input  logic [1:0]                 AXI_rresp,
  input  logic                       AXI_rvalid,
  output logic                       AXI_rready
);
  localparam int STRB_W = AXI_Dwidth / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

  state_t                     state, state_nxt;
  logic                       aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                       awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [AXI_Addrwidth-1:0]   awaddr_nxt, araddr_nxt;
  logic [AXI_Dwidth-1:0]      wdata_nxt, rsp_rdata_nxt;
  logic [STRB_W-1:0]          wstrb_nxt;
  logic                       rsp_valid_nxt, rsp_write_nxt;
  logic [1:0]                 rsp_resp_nxt;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
  localparam logic [AXI_Addrwidth-1:0] ALIGN_MASK = AXI_Addrwidth'(STRB_W - 1);
  logic misaligned;
  assign misaligned = |(cmd_addr & ALIGN_MASK);
`endif

  assign cmd_ready     = (state == IDLE);
  assign AXI_arprotect = AXI_Prot;

  always_comb begin
    state_nxt     = state;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    awvalid_nxt   = AXI_awvalid;
    wvalid_nxt    = AXI_wvalid;
    bready_nxt    = AXI_bready;
    arvalid_nxt   = AXI_arvalid;
    rready_nxt    = AXI_rready;
    awaddr_nxt    = AXI_awaddr;
    araddr_nxt    = AXI_areadaddr;
    wdata_nxt     = AXI_wdata;
    wstrb_nxt     = AXI_wstrb;
    rsp_valid_nxt = rsp_valid;
    rsp_write_nxt = rsp_write;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
`ifdef AXI_MASTER_ALIGN_CHECK_EN
          if (misaligned) begin
            state_nxt     = RSP;
            rsp_valid_nxt = 1'b1;
            rsp_resp_nxt  = 2'b10;
            rsp_rdata_nxt = '0;
            rsp_write_nxt = cmd_write;
          end else
`endif
          if (cmd_write) begin
            state_nxt   = WR;
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end else begin
            state_nxt   = RD_A;
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; B is only awaited once both are done.
        if (AXI_awvalid && AXI_awready) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (AXI_wvalid && AXI_wready) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt  = WR_B;
          bready_nxt = 1'b1;
        end
      end
      WR_B: begin
        if (AXI_bvalid && AXI_bready) begin
          state_nxt     = RSP;
          bready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_resp_nxt  = AXI_bresp;
        end
      end
      RD_A: begin
        if (AXI_arvalid && AXI_arready) begin
          state_nxt   = RD_R;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      RD_R: begin
        if (AXI_rvalid && AXI_rready) begin
          state_nxt     = RSP;
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_rdata_nxt = AXI_rdata;
          rsp_resp_nxt  = AXI_rresp;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      AXI_awvalid   <= 1'b0;
      AXI_wvalid    <= 1'b0;
      AXI_bready    <= 1'b0;
      AXI_arvalid   <= 1'b0;
      AXI_rready    <= 1'b0;
      AXI_awaddr    <= '0;
      AXI_areadaddr <= '0;
      AXI_wdata     <= '0;
      AXI_wstrb     <= '0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      state         <= state_nxt;
      aw_done       <= aw_done_nxt;
      w_done        <= w_done_nxt;
      AXI_awvalid   <= awvalid_nxt;
      AXI_wvalid    <= wvalid_nxt;
      AXI_bready    <= bready_nxt;
      AXI_arvalid   <= arvalid_nxt;
      AXI_rready    <= rready_nxt;
      AXI_awaddr    <= awaddr_nxt;
      AXI_areadaddr <= araddr_nxt;
      AXI_wdata     <= wdata_nxt;
      AXI_wstrb     <= wstrb_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_write     <= rsp_write_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      rsp_resp      <= rsp_resp_nxt;
    end
  end
endmodule

// File: tb/tb_axi_4lite_master.sv
// Bench for axi_4lite_master: 4-word AXI4-Lite slave with per-channel ready/valid delays,
// an abstract memory/response model, directed steps plus randomized transactions.
module tb_axi_4lite_master;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic [2:0]    arprot;

  axi_4lite_master #(.AXI_Dwidth(DW), .AXI_Addrwidth(AW), .AXI_Prot(3'b000)) dut (
    .AXI_aclk(clk), .AXI_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AXI_awaddr(awaddr), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_areadaddr(araddr), .AXI_arprotect(arprot), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < SW; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Slave knobs: cycles each valid waits before ready, and before bvalid/rvalid.
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] resp_code = 2'b00;

  logic          aw_got, w_got, ar_got;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;
  logic [DW-1:0] mem [4];

  assign awready = !aw_got && (aw_cnt >= aw_delay);
  assign wready  = !w_got  && (w_cnt  >= w_delay);
  assign arready = !ar_got && (ar_cnt >= ar_delay);

  wire aw_hs = awvalid && awready;
  wire w_hs  = wvalid && wready;
  wire ar_hs = arvalid && arready;
  wire [AW-1:0] wa_eff = aw_hs ? awaddr : aw_a;
  wire [DW-1:0] wd_eff = w_hs ? wdata : w_d;
  wire [SW-1:0] ws_eff = w_hs ? wstrb : w_s;
  wire [AW-1:0] ra_eff = ar_hs ? araddr : ar_a;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
        if (b_cnt >= b_delay) begin
          bvalid <= 1'b1; bresp <= resp_code; b_cnt <= 0;
          mem[wa_eff[3:2]] <= merge(mem[wa_eff[3:2]], wd_eff, ws_eff);
        end else b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
      if (ar_hs) begin ar_got <= 1'b1; ar_a <= araddr; ar_cnt <= 0; end
      else if (arvalid) ar_cnt <= ar_cnt + 1;
      if ((ar_got || ar_hs) && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid <= 1'b1; rdata <= mem[ra_eff[3:2]]; rresp <= resp_code; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) begin rvalid <= 1'b0; ar_got <= 1'b0; end
    end
  end

  // Valid/payload must hold from assertion until the handshake.
  int viol = 0;
  logic p_aw, p_w, p_ar;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
      p_awaddr <= '0; p_araddr <= '0; p_wdata <= '0; p_wstrb <= '0;
    end else begin
      if ((p_aw && (!awvalid || awaddr !== p_awaddr)) ||
          (p_w  && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) ||
          (p_ar && (!arvalid || araddr !== p_araddr)))
        viol <= viol + 1;
      p_aw <= awvalid && !awready; p_awaddr <= awaddr;
      p_w  <= wvalid && !wready;   p_wdata  <= wdata; p_wstrb <= wstrb;
      p_ar <= arvalid && !arready; p_araddr <= araddr;
    end
  end

  logic [DW-1:0] exp_mem [4];

  task automatic clear_model();
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (!cmd_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input int hold);
    logic [DW-1:0] e_rdata;
    logic [1:0]    e_resp;
    int e_lat, k, awv, wv, arv, busy_rdy;
    e_resp  = resp_code;
    e_rdata = wr ? '0 : exp_mem[a[3:2]];
    e_lat   = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                 : 3 + ar_delay + r_delay;
    if (wr) exp_mem[a[3:2]] = merge(exp_mem[a[3:2]], d, s);
    wait_idle(tag);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    // Junk command held while busy must be ignored.
    cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = $urandom; cmd_wstrb = ~s;
    k = 1; awv = 0; wv = 0; arv = 0; busy_rdy = 0;
    while (!rsp_valid && k < 300) begin
      if (awvalid) awv++;
      if (wvalid) wv++;
      if (arvalid) arv++;
      if (cmd_ready) busy_rdy++;
      @(posedge clk); #1; k++;
    end
    chk({tag, "_latency"}, DW'(k), DW'(e_lat));
    chk({tag, "_rsp_write"}, DW'(rsp_write), DW'(wr));
    chk({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
    chk({tag, "_rsp_resp"}, DW'(rsp_resp), DW'(e_resp));
    chk({tag, "_awvalid_cycles"}, DW'(awv), wr ? DW'(aw_delay + 1) : '0);
    chk({tag, "_wvalid_cycles"}, DW'(wv), wr ? DW'(w_delay + 1) : '0);
    chk({tag, "_arvalid_cycles"}, DW'(arv), wr ? '0 : DW'(ar_delay + 1));
    chk({tag, "_busy_cmd_ready"}, DW'(busy_rdy), '0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, DW'(rsp_valid), DW'(1));
      chk({tag, "_hold_rdata"}, rsp_rdata, e_rdata);
      chk({tag, "_hold_cmd_ready"}, DW'(cmd_ready), '0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk({tag, "_rsp_done"}, DW'(rsp_valid), '0);
    chk({tag, "_back_idle"}, DW'(cmd_ready), DW'(1));
  endtask

  initial begin
    logic [1:0] ri;
    logic       rw;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", DW'(awvalid), '0);
    chk("rst_wvalid", DW'(wvalid), '0);
    chk("rst_arvalid", DW'(arvalid), '0);
    chk("rst_bready", DW'(bready), '0);
    chk("rst_rready", DW'(rready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_rsp_fields", DW'({rsp_write, rsp_resp}), '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_addrs", DW'({awaddr, araddr}), '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_wstrb", DW'(wstrb), '0);
    chk("arprot", DW'(arprot), '0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_cmd_ready", DW'(cmd_ready), DW'(1));

    run_txn("wr0", 1'b1, 4'h0, 32'h0000_000A, 4'hF, 0);
    chk("led", DW'(mem[0][3:0]), DW'(4'hA));
    run_txn("rd0", 1'b0, 4'h0, '0, '0, 0);
    chk("rd0_model", exp_mem[0], 32'h0000_000A);

    aw_delay = 3;
    run_txn("wr4_awdly", 1'b1, 4'h4, 32'h1234_5678, 4'hF, 0);
    aw_delay = 0;
    run_txn("rd4", 1'b0, 4'h4, '0, '0, 0);

    run_txn("wr8", 1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, 0);
    run_txn("rd8_hold", 1'b0, 4'h8, '0, '0, 5);

    resp_code = 2'b10;
    run_txn("wr_slverr", 1'b1, 4'h4, 32'hCAFE_0000, 4'hC, 0);
    resp_code = 2'b11;
    run_txn("rd_decerr", 1'b0, 4'h4, '0, '0, 1);
    resp_code = 2'b00;

    // Abort while AW is still pending.
    aw_delay = 5;
    wait_idle("abort");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_awvalid_before", DW'(awvalid), DW'(1));
    #2 rstn = 1'b0;
    #1;
    chk("abort_awvalid", DW'(awvalid), '0);
    chk("abort_wvalid", DW'(wvalid), '0);
    chk("abort_rsp_valid", DW'(rsp_valid), '0);
    chk("abort_awaddr", DW'(awaddr), '0);
    clear_model();
    aw_delay = 0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_cmd_ready", DW'(cmd_ready), DW'(1));
    run_txn("wrC", 1'b1, 4'hC, 32'h0000_0003, 4'hF, 0);
    run_txn("rdC", 1'b0, 4'hC, '0, '0, 0);
    run_txn("rd8_cleared", 1'b0, 4'h8, '0, '0, 0);

`ifdef AXI_MASTER_ALIGN_CHECK_EN
    wait_idle("mis");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mis_rsp_valid", DW'(rsp_valid), DW'(1));
    chk("mis_rsp_resp", DW'(rsp_resp), DW'(2'b10));
    chk("mis_rsp_write", DW'(rsp_write), DW'(1));
    chk("mis_rsp_rdata", rsp_rdata, '0);
    chk("mis_no_axi", DW'({awvalid, wvalid, arvalid}), '0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("mis_back_idle", DW'(cmd_ready), DW'(1));
    chk("mis_no_write", mem[0], exp_mem[0]);
`endif

    for (int t = 0; t < 24; t++) begin
      aw_delay  = $urandom_range(0, 3);
      w_delay   = $urandom_range(0, 3);
      b_delay   = $urandom_range(0, 2);
      ar_delay  = $urandom_range(0, 3);
      r_delay   = $urandom_range(0, 2);
      resp_code = 2'($urandom_range(0, 3));
      ri = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", t), rw, {ri, 2'b00}, $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    chk("protocol_stable", DW'(viol), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
